// File: rtl/err_metric_accum.sv
// Error-metric accumulator for approximate-adder characterisation.
// Two-stage pipeline: error distance, then accumulation of count/max/sum/sum-of-squares.
module err_metric_accum #(
  parameter int W  = 16,
  parameter int NW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NW-1:0]         num_samples,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in1,
  input  logic [W-1:0]          in2,
  input  logic [W:0]            approx_sum,
  output logic                  busy,
  output logic                  done,
  output logic [NW-1:0]         err_count,
  output logic [W:0]            max_ed,
  output logic [W+NW:0]         sum_ed,
  output logic [2*W+1+NW:0]     sum_sq_ed
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [NW-1:0]   remaining;
  logic            s1_valid, s2_valid;
  logic [W:0]      s1_ed;
  logic            start_ok, accept, enter_done;
  logic [W:0]      exact, ed_in;
  logic [2*W+1:0]  sq;

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign accept   = in_valid && (state == RUN);
  assign in_ready = (state == RUN);
  assign busy     = (state == RUN) || (state == DRAIN);

  assign exact = {1'b0, in1} + {1'b0, in2};
  assign ed_in = (exact >= approx_sum) ? (exact - approx_sum) : (approx_sum - exact);
  assign sq    = {{(W+1){1'b0}}, s1_ed} * {{(W+1){1'b0}}, s1_ed};

  always_comb begin
    state_nxt  = state;
    enter_done = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (num_samples == '0) begin
            state_nxt  = DONE;
            enter_done = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (accept && (remaining == NW'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!s1_valid && !s2_valid) begin
          state_nxt  = DONE;
          enter_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_ed     <= '0;
      done      <= 1'b0;
      err_count <= '0;
      max_ed    <= '0;
      sum_ed    <= '0;
      sum_sq_ed <= '0;
    end else begin
      state    <= state_nxt;
      done     <= enter_done;
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (accept) s1_ed <= ed_in;
      // start is only honoured with an empty pipeline, so clearing here cannot race an accumulate
      if (start_ok) begin
        remaining <= num_samples;
        err_count <= '0;
        max_ed    <= '0;
        sum_ed    <= '0;
        sum_sq_ed <= '0;
      end else begin
        if (accept) remaining <= remaining - NW'(1);
        if (s1_valid) begin
          sum_ed    <= sum_ed + {{NW{1'b0}}, s1_ed};
          sum_sq_ed <= sum_sq_ed + {{NW{1'b0}}, sq};
          if (s1_ed != '0) err_count <= err_count + NW'(1);
          if (s1_ed > max_ed) max_ed <= s1_ed;
        end
      end
    end
  end

endmodule

// File: tb/tb_err_metric_accum.sv
// Scoreboarded bench for err_metric_accum: runs are modelled with plain arithmetic,
// expected results are queued and checked by a monitor when done pulses.
module tb_err_metric_accum;
  localparam int W  = 16;
  localparam int NW = 16;

  logic              clk = 1'b0;
  logic              rst_n, start, in_valid, in_ready, busy, done;
  logic [NW-1:0]     num_samples;
  logic [W-1:0]      in1, in2;
  logic [W:0]        approx_sum;
  logic [NW-1:0]     err_count;
  logic [W:0]        max_ed;
  logic [W+NW:0]     sum_ed;
  logic [2*W+1+NW:0] sum_sq_ed;

  err_metric_accum #(.W(W), .NW(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .approx_sum(approx_sum), .busy(busy), .done(done), .err_count(err_count),
    .max_ed(max_ed), .sum_ed(sum_ed), .sum_sq_ed(sum_sq_ed)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned ec, mx, se, ssq;
    time             t;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  longint unsigned m_ec, m_mx, m_se, m_ssq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_results(input string tag, input longint unsigned ec, input longint unsigned mx,
                             input longint unsigned se, input longint unsigned ssq);
    chk({tag, ".err_count"}, 64'(err_count), ec);
    chk({tag, ".max_ed"},    64'(max_ed),    mx);
    chk({tag, ".sum_ed"},    64'(sum_ed),    se);
    chk({tag, ".sum_sq_ed"}, 64'(sum_sq_ed), ssq);
  endtask

  // monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: actual=1 required=0 at time %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk_results("done", e.ec, e.mx, e.se, e.ssq);
        chk("done_time", 64'($time), 64'(e.t));
      end
    end
  end

  task automatic do_start(input int n);
    time ts;
    @(negedge clk);
    start       = 1'b1;
    num_samples = NW'(n);
    @(posedge clk);
    ts = $time;
    #1 start = 1'b0;
    m_ec = 0; m_mx = 0; m_se = 0; m_ssq = 0;
    if (n == 0) q.push_back('{ec: 0, mx: 0, se: 0, ssq: 0, t: ts + 5});
    @(negedge clk);
    chk_results("cleared", 0, 0, 0, 0);
    chk("busy_after_start", 64'(busy), 64'(n != 0));
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] s,
                      input int gap, input bit last);
    bit              acc, rdy;
    int              tries;
    time             ta;
    longint unsigned ex, ed;
    acc = 0; tries = 0; ta = 0;
    repeat (gap) @(negedge clk) in_valid = 1'b0;
    while (!acc && tries < 20) begin
      @(negedge clk);
      in_valid = 1'b1; in1 = a; in2 = b; approx_sum = s;
      rdy = in_ready;
      @(posedge clk);
      ta = $time;
      acc = rdy;
      tries++;
      #1 in_valid = 1'b0;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual=0 required=1");
    end
    ex = longint'(a) + longint'(b);
    ed = (ex > longint'(s)) ? ex - longint'(s) : longint'(s) - ex;
    if (ed != 0) m_ec++;
    if (ed > m_mx) m_mx = ed;
    m_se  += ed;
    m_ssq += ed * ed;
    if (last) q.push_back('{ec: m_ec, mx: m_mx, se: m_se, ssq: m_ssq, t: ta + 35});
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: actual=%0d pending required=0", q.size());
      q.delete();
    end
  endtask

  task automatic rand_sample(output logic [W-1:0] a, output logic [W-1:0] b, output logic [W:0] s);
    logic [W:0] ex;
    a  = W'($urandom);
    b  = W'($urandom);
    ex = {1'b0, a} + {1'b0, b};
    case ($urandom_range(0, 3))
      0: s = ex;
      1: s = ex + (W+1)'($urandom_range(0, 7));
      2: s = ex - (W+1)'($urandom_range(0, 7));
      default: s = (W+1)'($urandom);
    endcase
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b;
    logic [W:0]   s;
    int           n;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; num_samples = '0;
    in1 = '0; in2 = '0; approx_sum = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_results("reset", 0, 0, 0, 0);
    chk("reset.in_ready", 64'(in_ready), 0);
    chk("reset.busy", 64'(busy), 0);
    chk("reset.done", 64'(done), 0);
    rst_n = 1'b1;

    // single sample: 3+1 vs 2
    do_start(1);
    send(16'd3, 16'd1, 17'd2, 0, 1);
    wait_done();

    // exact run
    do_start(4);
    send(16'hFFFF, 16'hFFFF, 17'h1FFFE, 0, 0);
    send(16'd10, 16'd20, 17'd30, 0, 0);
    send(16'd0, 16'd0, 17'd0, 0, 0);
    send(16'h8000, 16'h8000, 17'h10000, 0, 1);
    wait_done();

    // mixed with bubbles: eds 1,0,3,2
    do_start(4);
    send(16'd5, 16'd5, 17'd11, 2, 0);
    send(16'd7, 16'd8, 17'd15, 0, 0);
    send(16'd10, 16'd0, 17'd7, 3, 0);
    send(16'd1, 16'd1, 17'd0, 1, 1);
    wait_done();

    // worst case
    do_start(2);
    send(16'hFFFF, 16'hFFFF, 17'd0, 0, 0);
    send(16'hFFFF, 16'hFFFF, 17'd0, 0, 1);
    wait_done();
    chk("worst.busy_in_done", 64'(busy), 0);

    // in_valid outside RUN is ignored; results hold in DONE
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1; in1 = W'($urandom); in2 = W'($urandom); approx_sum = '0;
    end
    @(negedge clk) in_valid = 1'b0;
    @(negedge clk);
    chk_results("hold", m_ec, m_mx, m_se, m_ssq);
    chk("hold.in_ready", 64'(in_ready), 0);

    // zero-length, then restart
    do_start(0);
    wait_done();
    do_start(3);
    send(16'd100, 16'd1, 17'd90, 0, 0);
    @(negedge clk);
    start = 1'b1; num_samples = '0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("ignored_start.busy", 64'(busy), 1);
    send(16'd2, 16'd2, 17'd4, 0, 0);
    send(16'd0, 16'd9, 17'd14, 1, 1);
    wait_done();

    // randomized runs
    repeat (12) begin
      n = $urandom_range(1, 8);
      do_start(n);
      for (int i = 0; i < n; i++) begin
        rand_sample(a, b, s);
        send(a, b, s, $urandom_range(0, 2), i == n - 1);
      end
      wait_done();
    end

    // reset mid-run: no done, all outputs cleared
    do_start(5);
    send(16'd1, 16'd1, 17'd5, 0, 0);
    send(16'd9, 16'd9, 17'd0, 0, 0);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    chk_results("midreset", 0, 0, 0, 0);
    chk("midreset.busy", 64'(busy), 0);
    chk("midreset.in_ready", 64'(in_ready), 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk_results("post_reset", 0, 0, 0, 0);
    chk("scoreboard_empty", 64'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
